fc_mem_read_mac: RTL and testbench

- Fully-connected output stage directly downstream of the pooling-2 output memory.
- On start, reads the 16 pooled activations from that memory together with a weight ROM and a bias ROM.
- Computes 10 class scores (one dot product plus bias per neuron) and writes them to a 10-entry FC output memory, then asserts done.
- Single MAC, sequential over neurons and inputs; all external memories are synchronous-read with 1-cycle latency.

---
 rtl/cnn_pkg.sv | 36 +++
 rtl/fc_mem_read_mac_mac_sat.sv | 51 +++++
 rtl/fc_mem_read_mac.sv | 126 ++++++++++++
 tb/tb_fc_mem_read_mac.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks: fixed-point widths,
// layer sizes, the FC sequencer state encoding and the output saturator.
package cnn_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int FRAC   = 8;
    localparam int N_IN   = 16;
    localparam int N_OUT  = 10;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } fc_state_t;

    // Clamp a wide signed value into the signed 16-bit output range.
    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > SAT_MAX) begin
            r = 16'sh7FFF;
        end else if (v < SAT_MIN) begin
            r = 16'sh8000;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_mem_read_mac_mac_sat.sv
// Single multiply-accumulate unit for the FC stage. The accumulator is
// Q24.16; the bias is loaded pre-shifted into that format, products are
// added as they arrive, and the next accumulator value is exposed already
// shifted back to Q8.8 and saturated so the sequencer can latch it on the
// same edge that folds in the last product.
module mac_sat
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load_bias,
    input  logic              accumulate,
    input  logic [DATA_W-1:0] bias,
    input  logic [DATA_W-1:0] act,
    input  logic [DATA_W-1:0] weight,
    output logic [DATA_W-1:0] result_next
);

    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    product_ext;
    logic signed [ACC_W-1:0]    bias_ext;

    // Next accumulator value: clear has priority, then bias load, then add.
    always_comb begin
        product     = $signed(act) * $signed(weight);
        product_ext = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
        bias_ext    = {{(ACC_W-DATA_W-FRAC){bias[DATA_W-1]}}, bias, {FRAC{1'b0}}};
        acc_next    = acc;
        if (clear) begin
            acc_next = '0;
        end else if (load_bias) begin
            acc_next = bias_ext;
        end else if (accumulate) begin
            acc_next = acc + product_ext;
        end
        result_next = sat16(acc_next >>> FRAC);
    end

    // Accumulator register, cleared by reset so an aborted pass leaves nothing behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/fc_mem_read_mac.sv
// Fully-connected output stage: for each of the N_OUT neurons it fetches
// the bias, streams N_IN activation/weight pairs through one MAC and writes
// the saturated score to the FC output memory. All source memories have a
// one-cycle read latency, so each operand is consumed one cycle after its
// address is issued and a DRAIN cycle picks up the final product.
module fc_mem_read_mac
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [3:0]        p2_addr,
    input  logic [DATA_W-1:0] p2_data,
    output logic [7:0]        w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [3:0]        b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic [3:0]        out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_we,
    output logic              busy,
    output logic              done
);

    fc_state_t         state;
    logic [3:0]        j;
    logic [4:0]        i;
    logic              armed;
    logic              start_accept;
    logic              mac_load_bias;
    logic              mac_accumulate;
    logic [7:0]        w_base;
    logic [DATA_W-1:0] result_next;

    // Decode MAC control from the current state; start is only honoured once
    // a full clock edge has passed since reset was released.
    always_comb begin
        start_accept   = start && armed && ((state == IDLE) || (state == DONE));
        mac_load_bias  = (state == MAC) && (i == 5'd0);
        mac_accumulate = ((state == MAC) && (i != 5'd0)) || (state == DRAIN);
        w_base         = 8'(j * N_IN);
    end

    mac_sat u_mac_sat (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (start_accept),
        .load_bias   (mac_load_bias),
        .accumulate  (mac_accumulate),
        .bias        (b_data),
        .act         (p2_data),
        .weight      (w_data),
        .result_next (result_next)
    );

    // Sequencer: walks neurons and inputs, issues memory addresses one cycle
    // ahead of use and registers every output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            j        <= '0;
            i        <= '0;
            armed    <= 1'b0;
            p2_addr  <= '0;
            w_addr   <= '0;
            b_addr   <= '0;
            out_addr <= '0;
            out_data <= '0;
            out_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            armed  <= 1'b1;
            out_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_accept) begin
                        state  <= BIAS;
                        j      <= '0;
                        i      <= '0;
                        b_addr <= '0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                BIAS: begin
                    p2_addr <= '0;
                    w_addr  <= w_base;
                    i       <= '0;
                    state   <= MAC;
                end
                MAC: begin
                    i <= i + 5'd1;
                    if (i == 5'(N_IN - 1)) begin
                        state <= DRAIN;
                    end else begin
                        p2_addr <= p2_addr + 4'd1;
                        w_addr  <= w_addr + 8'd1;
                    end
                end
                DRAIN: begin
                    out_we   <= 1'b1;
                    out_addr <= j;
                    out_data <= result_next;
                    state    <= WRITE;
                end
                WRITE: begin
                    if (j == 4'(N_OUT - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        j      <= j + 4'd1;
                        b_addr <= j + 4'd1;
                        state  <= BIAS;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_mem_read_mac.sv
// Directed bench for fc_mem_read_mac with behavioural synchronous memories
// and a scoreboard of expected FC writes (address, score, cycle).
module tb_fc_mem_read_mac;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  p2_addr;
    logic [15:0] p2_data;
    logic [7:0]  w_addr;
    logic [15:0] w_data;
    logic [3:0]  b_addr;
    logic [15:0] b_data;
    logic [3:0]  out_addr;
    logic [15:0] out_data;
    logic        out_we;
    logic        busy;
    logic        done;

    logic [15:0] p2_mem [16];
    logic [15:0] w_mem  [256];
    logic [15:0] b_mem  [16];

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          edge_cnt     = 0;
    int          start_edge   = 0;
    int          pass_writes  = 0;
    logic [15:0] last_data    = 16'h0;

    fc_mem_read_mac dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .p2_addr  (p2_addr),
        .p2_data  (p2_data),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .out_addr (out_addr),
        .out_data (out_data),
        .out_we   (out_we),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Edge counter used to express timing relative to the sampled start edge.
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        p2_data <= p2_mem[p2_addr];
        w_data  <= w_mem[w_addr];
        b_data  <= b_mem[b_addr];
    end

    function automatic int cur_cycle();
        return edge_cnt - start_edge + 1;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference score: full-precision dot product, floor shift, clamp.
    function automatic logic [15:0] model(input int j);
        longint acc;
        acc = longint'($signed(b_mem[j])) * 256;
        for (int k = 0; k < 16; k++) begin
            acc += longint'($signed(p2_mem[k])) * longint'($signed(w_mem[j*16+k]));
        end
        acc = acc >>> 8;
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        return acc[15:0];
    endfunction

    // Pulse start for one edge and queue the ten expected writes of the pass.
    task automatic apply_stimulus();
        exp_t e;
        pass_writes = 0;
        start       = 1'b1;
        start_edge  = edge_cnt + 1;
        for (int j = 0; j < 10; j++) begin
            e.addr = 4'(j);
            e.data = model(j);
            e.cyc  = 19 + 19 * j;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cycle(input int target);
        int n = 0;
        while (cur_cycle() < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done_and_check(input string tag);
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_done_cycle"}, 32'(cur_cycle()), 32'd191);
        check_output({tag, "_done"}, 32'(done), 32'd1);
        check_output({tag, "_busy_low"}, 32'(busy), 32'd0);
        check_output({tag, "_writes"}, 32'(pass_writes), 32'd10);
        check_output({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard consumer: every write strobe must match the next queued entry.
    always @(negedge clk) begin
        if (out_we) begin
            check_output("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_output("wr_addr", 32'(out_addr), 32'(mon_e.addr));
                check_output("wr_data", 32'(out_data), 32'(mon_e.data));
                check_output("wr_cycle", 32'(cur_cycle()), 32'(mon_e.cyc));
            end
            last_data = out_data;
            pass_writes++;
        end
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        for (int k = 0; k < 16; k++) begin
            p2_mem[k] = 16'h0100;
            b_mem[k]  = 16'h0000;
        end
        for (int k = 0; k < 256; k++) w_mem[k] = 16'h0100;
        repeat (3) @(negedge clk);

        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_we", 32'(out_we), 32'd0);
        check_output("rst_out_data", 32'(out_data), 32'd0);
        check_output("rst_w_addr", 32'(w_addr), 32'd0);
        check_output("rst_p2_addr", 32'(p2_addr), 32'd0);

        // start on the same edge that first sees reset released is ignored
        reset_n = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("start_at_release_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check_output("start_at_release_we", 32'(pass_writes), 32'd0);

        // Ones pass with a stray start mid-pass
        apply_stimulus();
        check_output("ones_busy", 32'(busy), 32'd1);
        wait_cycle(50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("ones_busy_after_stray", 32'(busy), 32'd1);
        wait_done_and_check("ones");
        check_output("ones_value", 32'(last_data), 32'h1000);

        // Re-run from DONE
        @(negedge clk);
        apply_stimulus();
        check_output("rerun_done_clear", 32'(done), 32'd0);
        check_output("rerun_busy", 32'(busy), 32'd1);
        wait_done_and_check("rerun");
        check_output("rerun_value", 32'(last_data), 32'h1000);

        // Signed weights with fractional bias
        for (int k = 0; k < 16; k++) b_mem[k] = 16'h0080;
        for (int k = 0; k < 256; k++) w_mem[k] = 16'hFF00;
        @(negedge clk);
        apply_stimulus();
        wait_done_and_check("signed");
        check_output("signed_value", 32'(last_data), 32'hF080);

        // Positive saturation
        for (int k = 0; k < 16; k++) begin
            p2_mem[k] = 16'h7FFF;
            b_mem[k]  = 16'h0000;
        end
        for (int k = 0; k < 256; k++) w_mem[k] = 16'h7FFF;
        @(negedge clk);
        apply_stimulus();
        wait_done_and_check("satpos");
        check_output("satpos_value", 32'(last_data), 32'h7FFF);

        // Negative saturation
        for (int k = 0; k < 256; k++) w_mem[k] = 16'h8000;
        @(negedge clk);
        apply_stimulus();
        wait_done_and_check("satneg");
        check_output("satneg_value", 32'(last_data), 32'h8000);

        // Addressing: weight ROM holds its own address, bias = j
        for (int k = 0; k < 16; k++) begin
            p2_mem[k] = 16'h0100;
            b_mem[k]  = 16'(k);
        end
        for (int k = 0; k < 256; k++) w_mem[k] = 16'(k);
        @(negedge clk);
        apply_stimulus();
        for (int j = 0; j < 10; j++) begin
            wait_cycle(19 * j + 1);
            check_output("addr_b", 32'(b_addr), 32'(j));
            for (int k = 0; k < 16; k++) begin
                wait_cycle(19 * j + 2 + k);
                check_output("addr_w", 32'(w_addr), 32'(j * 16 + k));
                check_output("addr_p2", 32'(p2_addr), 32'(k));
            end
        end
        wait_done_and_check("addr");

        // Reset mid-pass aborts with all outputs cleared and no further writes
        for (int k = 0; k < 16; k++) b_mem[k] = 16'h0000;
        for (int k = 0; k < 256; k++) w_mem[k] = 16'h0100;
        @(negedge clk);
        apply_stimulus();
        wait_cycle(100);
        reset_n = 1'b0;
        #1;
        sb.delete();
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_done", 32'(done), 32'd0);
        check_output("midrst_we", 32'(out_we), 32'd0);
        check_output("midrst_out_data", 32'(out_data), 32'd0);
        check_output("midrst_out_addr", 32'(out_addr), 32'd0);
        check_output("midrst_w_addr", 32'(w_addr), 32'd0);
        check_output("midrst_p2_addr", 32'(p2_addr), 32'd0);
        check_output("midrst_b_addr", 32'(b_addr), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        pass_writes = 0;
        repeat (40) @(negedge clk);
        check_output("midrst_no_writes", 32'(pass_writes), 32'd0);
        check_output("midrst_idle_busy", 32'(busy), 32'd0);

        // Fresh pass after reset
        apply_stimulus();
        wait_done_and_check("fresh");
        check_output("fresh_value", 32'(last_data), 32'h1000);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
